// File: rtl/vta_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vta_mem_pkg
// Brief    : Shared opcode constants, responder state encoding and default
//            beat width for the VTA memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package vta_mem_pkg;

  // Request opcodes as carried on dpi_req_opcode
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  // Default beat width: one 8-byte word
  localparam int DATA_LEN = 64;

  // Responder control states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_FETCH = 2'd1,
    ST_RD_DATA  = 2'd2,
    ST_WR_DATA  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/vta_mem_ram.sv
`default_nettype none
// ============================================================================
// Module   : vta_mem_ram
// Brief    : Single-port word RAM, synchronous read with one cycle latency.
//            Read data holds its value on cycles without a read.
// Revision : 1.0 - initial release
// ============================================================================
module vta_mem_ram #(
  parameter int WORDS     = 1024,
  parameter int DATA_BITS = 64,
  parameter int AW        = $clog2(WORDS)
) (
  input  logic                 clock,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  output logic [DATA_BITS-1:0] rdata_o
);

  logic [DATA_BITS-1:0] mem_q [WORDS];
  logic [DATA_BITS-1:0] rdata_q;

  // One access per cycle: either commit a write or capture a read word
  always_ff @(posedge clock) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/vta_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : vta_mem_responder
// Brief    : Burst memory responder for the VTA DPI memory port. Accepts read
//            and write bursts of len+1 word beats, serves them from a local
//            RAM and flags protocol and range violations in a sticky err.
// Revision : 1.0 - initial release
// ============================================================================
module vta_mem_responder
  import vta_mem_pkg::*;
#(
  parameter int LEN_BITS  = 8,
  parameter int ADDR_BITS = 64,
  parameter int DATA_BITS = DATA_LEN,
  parameter int MEM_WORDS = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dpi_req_valid,
  input  logic                 dpi_req_opcode,
  input  logic [LEN_BITS-1:0]  dpi_req_len,
  input  logic [ADDR_BITS-1:0] dpi_req_addr,
  input  logic                 dpi_wr_valid,
  input  logic [DATA_BITS-1:0] dpi_wr_bits,
  output logic                 dpi_rd_valid,
  output logic [DATA_BITS-1:0] dpi_rd_bits,
  input  logic                 dpi_rd_ready,
  output logic                 busy,
  output logic                 err
);

  // Word index carries one spare MSB so index+k never wraps inside a burst
  localparam int IW = ADDR_BITS - 2;
  localparam int AW = $clog2(MEM_WORDS);
  localparam int BW = LEN_BITS + 1;
  localparam logic [IW-1:0] C_MEM_WORDS = IW'(MEM_WORDS);

  state_t               state_q, state_d;
  logic [LEN_BITS-1:0]  len_q, len_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 oor_q, oor_d;
  logic                 err_q, err_d;

  logic                 w_in_range;
  logic                 w_last;
  logic                 w_ram_en;
  logic                 w_ram_we;
  logic [DATA_BITS-1:0] w_ram_rdata;

  assign w_in_range = (idx_q < C_MEM_WORDS);
  assign w_last     = (beat_q == {1'b0, len_q});

  // Next-state, beat bookkeeping, RAM strobes and error detection
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    beat_d     = beat_q;
    rd_valid_d = rd_valid_q;
    oor_d      = oor_q;
    err_d      = err_q;
    w_ram_en   = 1'b0;
    w_ram_we   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (dpi_req_valid) begin
          len_d  = dpi_req_len;
          idx_d  = {1'b0, dpi_req_addr[ADDR_BITS-1:3]};
          beat_d = '0;
          if (dpi_req_addr[2:0] != 3'd0) begin
            err_d = 1'b1;
          end
          state_d = (dpi_req_opcode == OP_WR) ? ST_WR_DATA : ST_RD_FETCH;
        end
      end

      ST_RD_FETCH: begin
        // Out-of-range words are never read; the beat is returned as zero
        w_ram_en   = w_in_range;
        oor_d      = !w_in_range;
        rd_valid_d = 1'b1;
        if (!w_in_range) begin
          err_d = 1'b1;
        end
        state_d = ST_RD_DATA;
      end

      ST_RD_DATA: begin
        if (rd_valid_q && dpi_rd_ready) begin
          rd_valid_d = 1'b0;
          if (w_last) begin
            state_d = ST_IDLE;
          end else begin
            beat_d  = beat_q + BW'(1);
            idx_d   = idx_q + IW'(1);
            state_d = ST_RD_FETCH;
          end
        end
      end

      ST_WR_DATA: begin
        if (dpi_wr_valid) begin
          w_ram_en = w_in_range;
          w_ram_we = w_in_range;
          if (!w_in_range) begin
            err_d = 1'b1;
          end
          if (w_last) begin
            state_d = ST_IDLE;
          end else begin
            beat_d = beat_q + BW'(1);
            idx_d  = idx_q + IW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Requests arriving while a burst is in flight are dropped
    if (dpi_req_valid && (state_q != ST_IDLE)) begin
      err_d = 1'b1;
    end
    // Write beats are only meaningful inside a write burst
    if (dpi_wr_valid && (state_q != ST_WR_DATA)) begin
      err_d = 1'b1;
    end
    // A reset edge must not commit a write or disturb the read register
    if (reset) begin
      w_ram_en = 1'b0;
      w_ram_we = 1'b0;
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      beat_q     <= '0;
      rd_valid_q <= 1'b0;
      oor_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      beat_q     <= beat_d;
      rd_valid_q <= rd_valid_d;
      oor_q      <= oor_d;
      err_q      <= err_d;
    end
  end

  vta_mem_ram #(
    .WORDS     (MEM_WORDS),
    .DATA_BITS (DATA_BITS),
    .AW        (AW)
  ) u_ram (
    .clock   (clock),
    .en_i    (w_ram_en),
    .we_i    (w_ram_we),
    .addr_i  (idx_q[AW-1:0]),
    .wdata_i (dpi_wr_bits),
    .rdata_o (w_ram_rdata)
  );

  // RAM output register holds between fetches, so the beat stays stable
  // while the initiator stalls; it is masked to zero when no beat is offered.
  assign dpi_rd_valid = rd_valid_q;
  assign dpi_rd_bits  = (rd_valid_q && !oor_q) ? w_ram_rdata : '0;
  assign busy         = (state_q != ST_IDLE);
  assign err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_vta_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_vta_mem_responder
// Brief    : Self-checking bench for vta_mem_responder. A word-array memory
//            model supplies expected read beats; a negedge monitor compares
//            every offered beat and the handshake timing against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vta_mem_responder;

  localparam int LEN_BITS  = 8;
  localparam int ADDR_BITS = 64;
  localparam int DATA_BITS = 64;
  localparam int MEM_WORDS = 1024;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 dpi_req_valid = 1'b0;
  logic                 dpi_req_opcode = 1'b0;
  logic [LEN_BITS-1:0]  dpi_req_len = '0;
  logic [ADDR_BITS-1:0] dpi_req_addr = '0;
  logic                 dpi_wr_valid = 1'b0;
  logic [DATA_BITS-1:0] dpi_wr_bits = '0;
  logic                 dpi_rd_valid;
  logic [DATA_BITS-1:0] dpi_rd_bits;
  logic                 dpi_rd_ready = 1'b0;
  logic                 busy;
  logic                 err;

  int checks   = 0;
  int failures = 0;
  int hs_count = 0;

  logic [63:0] model_mem [MEM_WORDS];
  logic [63:0] exp_q [$];
  logic        exp_err = 1'b0;
  logic        prev_hs = 1'b0;

  vta_mem_responder #(
    .LEN_BITS  (LEN_BITS),
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS),
    .MEM_WORDS (MEM_WORDS)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .dpi_req_valid  (dpi_req_valid),
    .dpi_req_opcode (dpi_req_opcode),
    .dpi_req_len    (dpi_req_len),
    .dpi_req_addr   (dpi_req_addr),
    .dpi_wr_valid   (dpi_wr_valid),
    .dpi_wr_bits    (dpi_wr_bits),
    .dpi_rd_valid   (dpi_rd_valid),
    .dpi_rd_bits    (dpi_rd_bits),
    .dpi_rd_ready   (dpi_rd_ready),
    .busy           (busy),
    .err            (err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_rd(input longint unsigned idx);
    return (idx < MEM_WORDS) ? model_mem[idx] : 64'd0;
  endfunction

  // Inputs change just after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_err = 1'b0;
    exp_q.delete();
    tick();
  endtask

  task automatic do_write(input int len, input logic [63:0] addr, input logic [63:0] base);
    longint unsigned idx;
    dpi_req_valid  = 1'b1;
    dpi_req_opcode = 1'b1;
    dpi_req_len    = LEN_BITS'(len);
    dpi_req_addr   = addr;
    if (addr[2:0] != 3'd0) exp_err = 1'b1;
    tick();
    dpi_req_valid = 1'b0;
    chk("wr_busy", {63'd0, busy}, 64'd1);
    for (int k = 0; k <= len; k++) begin
      idx = longint'(addr >> 3) + longint'(k);
      dpi_wr_valid = 1'b1;
      dpi_wr_bits  = base + 64'(k);
      tick();
      if (idx < MEM_WORDS) model_mem[idx] = base + 64'(k);
      else exp_err = 1'b1;
    end
    dpi_wr_valid = 1'b0;
    chk("wr_done_busy", {63'd0, busy}, 64'd0);
  endtask

  // stall: cycles rd_ready is held low on beat 0; inject: second request mid-burst
  task automatic do_read(input int len, input logic [63:0] addr, input int stall, input bit inject);
    int cyc;
    longint unsigned idx;
    for (int k = 0; k <= len; k++) begin
      idx = longint'(addr >> 3) + longint'(k);
      exp_q.push_back(model_rd(idx));
      if (idx >= MEM_WORDS) exp_err = 1'b1;
    end
    if (addr[2:0] != 3'd0) exp_err = 1'b1;
    dpi_req_valid  = 1'b1;
    dpi_req_opcode = 1'b0;
    dpi_req_len    = LEN_BITS'(len);
    dpi_req_addr   = addr;
    dpi_rd_ready   = 1'b0;
    tick();
    dpi_req_valid = 1'b0;
    chk("rd_lat_c1", {63'd0, dpi_rd_valid}, 64'd0);
    tick();
    chk("rd_lat_c2", {63'd0, dpi_rd_valid}, 64'd1);
    for (int s = 0; s < stall; s++) begin
      if (inject && s == 0) begin
        dpi_req_valid  = 1'b1;
        dpi_req_opcode = 1'b1;
        dpi_req_len    = '0;
        dpi_req_addr   = 64'h40;
        exp_err        = 1'b1;
      end else begin
        dpi_req_valid = 1'b0;
      end
      tick();
    end
    dpi_req_valid = 1'b0;
    dpi_rd_ready  = 1'b1;
    cyc = 0;
    while ((exp_q.size() != 0 || busy) && cyc < 3000) begin
      tick();
      cyc++;
    end
    if (cyc >= 3000) begin
      checks++;
      failures++;
      $display("FAIL rd_timeout: %0d beats outstanding after %0d cycles", exp_q.size(), cyc);
      exp_q.delete();
    end
    dpi_rd_ready = 1'b0;
  endtask

  // Beat monitor: every offered beat matches the model front, rd_valid drops
  // after each handshake, and busy falls after the final handshake.
  always @(negedge clock) begin
    logic cur_hs;
    cur_hs = 1'b0;
    if (reset) begin
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) chk("rd_valid_drop", {63'd0, dpi_rd_valid}, 64'd0);
      if (prev_hs && exp_q.size() == 0) chk("busy_fall", {63'd0, busy}, 64'd0);
      if (dpi_rd_valid) begin
        if (exp_q.size() == 0) begin
          chk("rd_spurious", {63'd0, dpi_rd_valid}, 64'd0);
        end else begin
          chk("rd_bits", dpi_rd_bits, exp_q[0]);
          if (dpi_rd_ready) begin
            void'(exp_q.pop_front());
            hs_count++;
            cur_hs = 1'b1;
          end
        end
      end
      prev_hs = cur_hs;
    end
  end

  initial begin
    int h0;
    for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = 64'd0;

    // Reset state
    do_reset();
    chk("rst_rd_valid", {63'd0, dpi_rd_valid}, 64'd0);
    chk("rst_rd_bits", dpi_rd_bits, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);

    // 4-beat write then read back at 0x40
    do_write(3, 64'h40, 64'hA0);
    chk("model_w8", model_mem[8], 64'hA0);
    chk("model_w11", model_mem[11], 64'hA3);
    do_read(3, 64'h40, 0, 1'b0);
    chk("basic_err", {63'd0, err}, 64'd0);

    // Back-pressure on beat 0 for 5 cycles
    do_write(1, 64'h100, 64'h55);
    h0 = hs_count;
    do_read(1, 64'h100, 5, 1'b0);
    chk("stall_handshakes", 64'(hs_count - h0), 64'd2);
    chk("stall_err", {63'd0, err}, 64'd0);

    // Second request during a read burst
    do_read(3, 64'h40, 4, 1'b1);
    chk("inject_err", {63'd0, err}, {63'd0, exp_err});
    chk("inject_err_lit", {63'd0, err}, 64'd1);
    do_reset();

    // Write beat while idle, then data unaffected
    dpi_wr_valid = 1'b1;
    dpi_wr_bits  = 64'hDEAD;
    tick();
    dpi_wr_valid = 1'b0;
    exp_err = 1'b1;
    tick();
    chk("idle_wr_err", {63'd0, err}, 64'd1);
    do_read(3, 64'h40, 0, 1'b0);
    do_reset();

    // Misaligned address: low bits ignored, err raised
    do_read(0, 64'h43, 0, 1'b0);
    chk("misalign_err", {63'd0, err}, {63'd0, exp_err});
    do_reset();

    // Burst crossing the top of memory
    do_write(1, 64'h1FF8, 64'h77);
    do_read(1, 64'h1FF8, 0, 1'b0);
    chk("oor_err", {63'd0, err}, 64'd1);
    chk("oor_busy", {63'd0, busy}, 64'd0);
    do_reset();

    // Reset after beat 1 of a 4-beat write at 0x200
    do_write(1, 64'h210, 64'h11);
    dpi_req_valid  = 1'b1;
    dpi_req_opcode = 1'b1;
    dpi_req_len    = 8'd3;
    dpi_req_addr   = 64'h200;
    tick();
    dpi_req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      dpi_wr_valid = 1'b1;
      dpi_wr_bits  = 64'hC0 + 64'(k);
      tick();
      model_mem[64 + k] = 64'hC0 + 64'(k);
    end
    dpi_wr_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("abort_rd_valid", {63'd0, dpi_rd_valid}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    exp_err = 1'b0;
    tick();
    chk("model_w66", model_mem[66], 64'h11);
    do_read(3, 64'h200, 0, 1'b0);
    chk("abort_err", {63'd0, err}, 64'd0);

    // Full 256-beat write and read at address 0
    do_write(255, 64'h0, 64'h1_0000_0000);
    chk("model_w255", model_mem[255], 64'h1_0000_00FF);
    do_read(255, 64'h0, 0, 1'b0);
    chk("long_err", {63'd0, err}, 64'd0);
    chk("long_busy", {63'd0, busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
